// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue between IF and ID: circular buffer of {PC+4, instr} pairs.
// Optional same-cycle empty-queue bypass is enabled by defining PFQ_BYPASS_EN.
module if_prefetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_valid,
  output logic                         push_ready,
  input  logic [31:0]                  push_pc4,
  input  logic [31:0]                  push_instr,
  output logic                         pop_valid,
  input  logic                         pop_ready,
  output logic [31:0]                  pop_pc4,
  output logic [31:0]                  pop_instr,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [63:0]   mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

  logic          empty_s;
  logic          full_s;
  logic          bypass_s;
  logic          push_fire_s;
  logic          pop_fire_s;
  logic [63:0]   head_s;

  // Occupancy flags and the optional bypass qualifier
  always_comb begin
    empty_s = (count_r == {CW{1'b0}});
    full_s  = (count_r == FULL_CNT);
`ifdef PFQ_BYPASS_EN
    // rst_n gating keeps pop_valid low while reset is held
    bypass_s = empty_s && push_valid && !flush && rst_n;
`else
    bypass_s = 1'b0;
`endif
  end

  // Handshake qualification; a bypassed-and-consumed pair never touches storage
  always_comb begin
    push_fire_s = push_valid && !full_s && !flush && !(bypass_s && pop_ready);
    pop_fire_s  = !empty_s && pop_ready && !flush;
  end

  // Head selection and output gating
  always_comb begin
    if (bypass_s) begin
      head_s = {push_pc4, push_instr};
    end else begin
      head_s = mem_r[rd_ptr_r];
    end
    pop_valid  = !empty_s || bypass_s;
    push_ready = !full_s;
    if (pop_valid) begin
      pop_pc4   = head_s[63:32];
      pop_instr = head_s[31:0];
    end else begin
      pop_pc4   = 32'h0000_0000;
      pop_instr = 32'h0000_0000;
    end
    count = count_r;
  end

  // Pointer and occupancy state; flush outranks push and pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_fire_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_fire_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_fire_s, pop_fire_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Pair storage; contents are don't-care while unoccupied, so no reset
  always_ff @(posedge clk) begin
    if (push_fire_s) begin
      mem_r[wr_ptr_r] <= {push_pc4, push_instr};
    end
  end

endmodule
